mem_access_unit: RTL and testbench

- MEM-stage data-memory access unit. Sits directly downstream of the EX/MEM pipeline register and consumes its mem_read, mem_write, alu_result (address) and read_data2 (store data) outputs.
- Converts RV32IM load/store ops into word-wide transactions on a req/ack data-memory bus.
- Aligns and sign- or zero-extends load data.
- Drives busywait back to the pipeline registers to stall them while an access is outstanding.

---
 rtl/mem_pkg.sv | 27 ++
 rtl/load_align_ext.sv | 27 ++
 rtl/mem_access_unit.sv | 194 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage access unit and the load alignment block:
// load/store funct3 values, access sizes and the access FSM state encoding.
package mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] ST_SB = 2'b00;
    localparam logic [1:0] ST_SH = 2'b01;
    localparam logic [1:0] ST_SW = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } mem_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_e;

endpackage

// File: rtl/load_align_ext.sv
// Combinational load-data alignment: picks the byte/halfword addressed by
// off_in out of a 32-bit word and sign- or zero-extends it per funct3.
module load_align_ext
    import mem_pkg::*;
(
    input  logic [31:0] rdata_in,
    input  logic [1:0]  off_in,
    input  logic [2:0]  funct3_in,
    output logic [31:0] data_out
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_in[8*off_in +: 8];
        half_sel = off_in[1] ? rdata_in[31:16] : rdata_in[15:0];
        case (funct3_in)
            F3_LB:   data_out = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data_out = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  data_out = {24'd0, byte_sel};
            F3_LHU:  data_out = {16'd0, half_sel};
            default: data_out = rdata_in;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: IDLE -> ACCESS -> DONE per load/store,
// stalling the pipeline via busywait. Optional watchdog: MEM_ACCESS_TIMEOUT_EN.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        mem_read_in,
    input  logic [2:0]        mem_write_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [31:0]       write_data_in,
    output logic              busywait,
    output logic [31:0]       load_data_out,
    output logic              misaligned_out,
    output logic              bus_error_out,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_byte_en,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_ack
);

    mem_state_e        state_q, state_d;
    logic              dmem_read_q, dmem_read_d;
    logic              dmem_write_q, dmem_write_d;
    logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
    logic [31:0]       dmem_wdata_q, dmem_wdata_d;
    logic [3:0]        byte_en_q, byte_en_d;
    logic [31:0]       load_data_q, load_data_d;
    logic              bus_error_q, bus_error_d;
    logic [2:0]        ld_funct3_q, ld_funct3_d;
    logic [1:0]        ld_off_q, ld_off_d;

    logic              load_en, store_en, op_valid, misaligned;
    mem_size_e         op_size;
    logic [31:0]       aligned_data;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
`else
    localparam int UNUSED_TIMEOUT_CYCLES = TIMEOUT_CYCLES;
`endif

    load_align_ext u_align (
        .rdata_in  (dmem_rdata),
        .off_in    (ld_off_q),
        .funct3_in (ld_funct3_q),
        .data_out  (aligned_data)
    );

    // Store wins when both enables are set; unknown encodings fall back to word.
    always_comb begin
        load_en  = mem_read_in[3];
        store_en = mem_write_in[2];
        op_size  = SZ_WORD;
        if (store_en) begin
            case (mem_write_in[1:0])
                ST_SB:   op_size = SZ_BYTE;
                ST_SH:   op_size = SZ_HALF;
                default: op_size = SZ_WORD;
            endcase
        end else begin
            case (mem_read_in[2:0])
                F3_LB, F3_LBU: op_size = SZ_BYTE;
                F3_LH, F3_LHU: op_size = SZ_HALF;
                default:       op_size = SZ_WORD;
            endcase
        end
        misaligned = (load_en || store_en) &&
                     (((op_size == SZ_HALF) && addr_in[0]) ||
                      ((op_size == SZ_WORD) && (addr_in[1:0] != 2'b00)));
        op_valid   = (load_en || store_en) && !misaligned;
    end

    always_comb begin
        state_d      = state_q;
        dmem_read_d  = dmem_read_q;
        dmem_write_d = dmem_write_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        byte_en_d    = byte_en_q;
        load_data_d  = load_data_q;
        bus_error_d  = 1'b0;
        ld_funct3_d  = ld_funct3_q;
        ld_off_d     = ld_off_q;
        busywait     = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    busywait     = 1'b1;
                    state_d      = S_ACCESS;
                    dmem_read_d  = !store_en;
                    dmem_write_d = store_en;
                    dmem_addr_d  = {addr_in[ADDR_W-1:2], 2'b00};
                    ld_funct3_d  = mem_read_in[2:0];
                    ld_off_d     = addr_in[1:0];
                    dmem_wdata_d = 32'd0;
                    byte_en_d    = 4'b1111;
                    if (store_en) begin
                        case (op_size)
                            SZ_BYTE: begin
                                dmem_wdata_d = {4{write_data_in[7:0]}};
                                byte_en_d    = 4'b0001 << addr_in[1:0];
                            end
                            SZ_HALF: begin
                                dmem_wdata_d = {2{write_data_in[15:0]}};
                                byte_en_d    = addr_in[1] ? 4'b1100 : 4'b0011;
                            end
                            default: dmem_wdata_d = write_data_in;
                        endcase
                    end
`ifdef MEM_ACCESS_TIMEOUT_EN
                    tmo_cnt_d = TMO_LOAD;
`endif
                end
            end
            S_ACCESS: begin
                busywait = 1'b1;
                if (dmem_ack) begin
                    dmem_read_d  = 1'b0;
                    dmem_write_d = 1'b0;
                    state_d      = S_DONE;
                    if (dmem_read_q) load_data_d = aligned_data;
                end
`ifdef MEM_ACCESS_TIMEOUT_EN
                else if (tmo_cnt_q == '0) begin
                    dmem_read_d  = 1'b0;
                    dmem_write_d = 1'b0;
                    bus_error_d  = 1'b1;
                    load_data_d  = 32'd0;
                    state_d      = S_DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - 1'b1;
                end
`endif
            end
            // One non-stalled cycle lets EX/MEM advance before a new op is seen.
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            dmem_read_q  <= 1'b0;
            dmem_write_q <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            byte_en_q    <= '0;
            load_data_q  <= '0;
            bus_error_q  <= 1'b0;
            ld_funct3_q  <= '0;
            ld_off_q     <= '0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            tmo_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            dmem_read_q  <= dmem_read_d;
            dmem_write_q <= dmem_write_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            byte_en_q    <= byte_en_d;
            load_data_q  <= load_data_d;
            bus_error_q  <= bus_error_d;
            ld_funct3_q  <= ld_funct3_d;
            ld_off_q     <= ld_off_d;
`ifdef MEM_ACCESS_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
`endif
        end
    end

    assign misaligned_out = misaligned;
    assign bus_error_out  = bus_error_q;
    assign dmem_read      = dmem_read_q;
    assign dmem_write     = dmem_write_q;
    assign dmem_addr      = dmem_addr_q;
    assign dmem_wdata     = dmem_wdata_q;
    assign dmem_byte_en   = byte_en_q;
    assign load_data_out  = load_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: the bench plays the data memory, drives
// one op at a time and checks strobes, lanes, stall length and load results.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic [3:0]  mem_read_in;
    logic [2:0]  mem_write_in;
    logic [31:0] addr_in;
    logic [31:0] write_data_in;
    logic        busywait;
    logic [31:0] load_data_out;
    logic        misaligned_out;
    logic        bus_error_out;
    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_byte_en;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    int n_vec = 0;
    int n_err = 0;

    int          busy_cnt, rd_cnt, wr_cnt, txn_cnt;
    logic        mis_first, err_seen, op_finished;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;

    mem_access_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_read_in    (mem_read_in),
        .mem_write_in   (mem_write_in),
        .addr_in        (addr_in),
        .write_data_in  (write_data_in),
        .busywait       (busywait),
        .load_data_out  (load_data_out),
        .misaligned_out (misaligned_out),
        .bus_error_out  (bus_error_out),
        .dmem_read      (dmem_read),
        .dmem_write     (dmem_write),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_byte_en   (dmem_byte_en),
        .dmem_rdata     (dmem_rdata),
        .dmem_ack       (dmem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one op at posedge+1, acks after wait_cycles strobe cycles, and
    // withdraws the op at the edge where busywait is low (pipeline advances).
    task automatic do_op(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rdat, input int wait_cycles);
        int   waited;
        logic prev_strobe, strobe;
        busy_cnt = 0; rd_cnt = 0; wr_cnt = 0; txn_cnt = 0;
        err_seen = 0; mis_first = 0; op_finished = 0;
        waited = 0; prev_strobe = 0;
        mem_read_in = rd; mem_write_in = wr; addr_in = addr;
        write_data_in = wd; dmem_rdata = rdat;
        for (int i = 0; i < 30 && !op_finished; i++) begin
            if (dmem_read || dmem_write) begin
                dmem_ack = (waited == wait_cycles);
                waited++;
            end else begin
                dmem_ack = 1'b0;
            end
            @(negedge clk);
            if (i == 0) mis_first = misaligned_out;
            strobe = dmem_read | dmem_write;
            if (strobe && !prev_strobe) begin
                txn_cnt++;
                cap_addr = dmem_addr; cap_be = dmem_byte_en; cap_wdata = dmem_wdata;
            end
            prev_strobe = strobe;
            if (dmem_read)  rd_cnt++;
            if (dmem_write) wr_cnt++;
            if (busywait) busy_cnt++;
            else begin
                op_finished = 1'b1;
                err_seen = bus_error_out;
            end
            @(posedge clk); #1;
        end
        chk("op_finished", 32'(op_finished), 32'd1);
        mem_read_in = 4'd0; mem_write_in = 3'd0; dmem_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        mem_read_in = 4'd0; mem_write_in = 3'd0; addr_in = 32'd0;
        write_data_in = 32'd0; dmem_rdata = 32'd0; dmem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",    32'(busywait), 32'd0);
        chk("rst_rd",      32'(dmem_read), 32'd0);
        chk("rst_wr",      32'(dmem_write), 32'd0);
        chk("rst_load",    load_data_out, 32'd0);
        chk("rst_addr",    dmem_addr, 32'd0);
        chk("rst_be",      32'(dmem_byte_en), 32'd0);
        chk("rst_berr",    32'(bus_error_out), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // LB 0x103, two wait cycles
        do_op(4'b1000, 3'b000, 32'h103, 32'h0, 32'h80AABBCC, 2);
        chk("lb_be",   32'(cap_be), 32'hF);
        chk("lb_addr", cap_addr, 32'h100);
        chk("lb_data", load_data_out, 32'hFFFFFF80);
        chk("lb_busy", 32'(busy_cnt), 32'd4);
        chk("lb_rdcyc", 32'(rd_cnt), 32'd3);
        chk("lb_wr",   32'(wr_cnt), 32'd0);

        // LHU 0x102, ack in first ACCESS cycle
        do_op(4'b1101, 3'b000, 32'h102, 32'h0, 32'h80011234, 0);
        chk("lhu_data", load_data_out, 32'h00008001);
        chk("lhu_busy", 32'(busy_cnt), 32'd2);
        chk("lhu_rdcyc", 32'(rd_cnt), 32'd1);

        // SB 0x201
        do_op(4'b0000, 3'b100, 32'h201, 32'h000000A5, 32'h0, 0);
        chk("sb_addr",  cap_addr, 32'h200);
        chk("sb_be",    32'(cap_be), 32'h2);
        chk("sb_wdata", cap_wdata, 32'hA5A5A5A5);
        chk("sb_wrcyc", 32'(wr_cnt), 32'd1);
        chk("sb_keep",  load_data_out, 32'h00008001);

        // SW 0x102 is misaligned and dropped
        do_op(4'b0000, 3'b110, 32'h102, 32'h11223344, 32'h0, 0);
        chk("swmis_flag", 32'(mis_first), 32'd1);
        chk("swmis_busy", 32'(busy_cnt), 32'd0);
        chk("swmis_txn",  32'(txn_cnt), 32'd0);

        // back-to-back LW then SW
        do_op(4'b1010, 3'b000, 32'h104, 32'h0, 32'h12345678, 1);
        chk("lw_txn",  32'(txn_cnt), 32'd1);
        chk("lw_data", load_data_out, 32'h12345678);
        chk("lw_addr", cap_addr, 32'h104);
        do_op(4'b0000, 3'b110, 32'h108, 32'hDEADBEEF, 32'h0, 0);
        chk("sw_txn",   32'(txn_cnt), 32'd1);
        chk("sw_be",    32'(cap_be), 32'hF);
        chk("sw_wdata", cap_wdata, 32'hDEADBEEF);
        chk("sw_rd",    32'(rd_cnt), 32'd0);

        // remaining load extractions and SH lanes
        do_op(4'b1001, 3'b000, 32'h106, 32'h0, 32'h80017FFF, 0);
        chk("lh_data", load_data_out, 32'hFFFF8001);
        do_op(4'b1000, 3'b000, 32'h100, 32'h0, 32'h0000007F, 0);
        chk("lb_pos",  load_data_out, 32'h0000007F);
        do_op(4'b1100, 3'b000, 32'h101, 32'h0, 32'h0000FF00, 0);
        chk("lbu_data", load_data_out, 32'h000000FF);
        do_op(4'b0000, 3'b101, 32'h10A, 32'h0000BEEF, 32'h0, 0);
        chk("sh_be",    32'(cap_be), 32'hC);
        chk("sh_wdata", cap_wdata, 32'hBEEFBEEF);
        chk("sh_addr",  cap_addr, 32'h108);

        // read and write together: write only
        do_op(4'b1010, 3'b110, 32'h110, 32'hCAFEF00D, 32'h55555555, 0);
        chk("both_wr",   32'(wr_cnt), 32'd1);
        chk("both_rd",   32'(rd_cnt), 32'd0);
        chk("both_keep", load_data_out, 32'h000000FF);

        // LH at odd address
        do_op(4'b1001, 3'b000, 32'h101, 32'h0, 32'h0, 0);
        chk("lhmis_flag", 32'(mis_first), 32'd1);
        chk("lhmis_busy", 32'(busy_cnt), 32'd0);

        // stray ack while idle
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
        repeat (3) @(posedge clk);
        #1;
        chk("idleack_load", load_data_out, 32'h000000FF);
        chk("idleack_busy", 32'(busywait), 32'd0);
        dmem_ack = 1'b0;

`ifdef MEM_ACCESS_TIMEOUT_EN
        do_op(4'b1010, 3'b000, 32'h130, 32'h0, 32'h0, 99);
        chk("tmo_busy", 32'(busy_cnt), 32'd5);
        chk("tmo_err",  32'(err_seen), 32'd1);
        chk("tmo_load", load_data_out, 32'd0);
        @(negedge clk);
        chk("tmo_pulse", 32'(bus_error_out), 32'd0);
        @(posedge clk); #1;
`else
        chk("noerr", 32'(bus_error_out), 32'd0);
`endif

        // reset in the middle of an LW
        mem_read_in = 4'b1010; addr_in = 32'h120; dmem_rdata = 32'h0;
        @(posedge clk); #1;
        chk("mid_rd_pre", 32'(dmem_read), 32'd1);
        #2;
        rst = 1'b0; mem_read_in = 4'd0;
        #1;
        chk("mid_rd",   32'(dmem_read), 32'd0);
        chk("mid_busy", 32'(busywait), 32'd0);
        chk("mid_load", load_data_out, 32'd0);
        chk("mid_addr", dmem_addr, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rd", 32'(dmem_read), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
